video_pattern_checker: RTL and testbench
========================================

Name: video_pattern_checker

Overview:
- Consumer end of the 24-bit Video/VideoValid/VideoReady pixel stream driven by the DVI pattern generator.
- Accepts pixels in raster order and compares each one against the expected vertical-stripe test pattern.
- Counts mismatches and completed frames, and records the coordinates of the first error.
- Can stall the stream on a fixed schedule so the generator's backpressure handling is exercised in simulation and on the FPGA.

Parameters:
- H_ACTIVE, 800: pixels per line.
- V_ACTIVE, 600: lines per frame.
- STRIPE_LOG2, 6: stripe width is 2^STRIPE_LOG2 pixels (64).
- COLOR_A, 24'hFF33FF: expected colour in even stripes.
- COLOR_B, 24'hFF3333: expected colour in odd stripes.
- STALL_PERIOD, 0: when nonzero, VideoReady is dropped for 1 cycle every STALL_PERIOD cycles; 0 means never stall.

Ports:
- clock  in  1  system clock; all state is sampled on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- Enable  in  1  checker runs while high.
- Video  in  24  pixel data, {R,G,B}.
- VideoValid  in  1  producer has a valid pixel on Video.
- VideoReady  out  1  checker accepts a pixel this cycle.
- ErrorCount  out  16  mismatched pixels seen; saturates.
- FrameCount  out  16  completed frames; wraps.
- ErrorFlag  out  1  sticky: at least one mismatch seen.
- FirstErrX  out  10  x coordinate of the first mismatch.
- FirstErrY  out  10  y coordinate of the first mismatch.
- FrameDone  out  1  one-cycle pulse when the last pixel of a frame is accepted.

Behaviour:
- Reset: on assertion of reset, asynchronously clear every register and output to 0. This includes VideoReady, ErrorCount, FrameCount, ErrorFlag, FirstErrX, FirstErrY, FrameDone, the x/y counters, the stall counter and the FSM (goes to IDLE). Reset mid-frame discards the partial frame; the next accepted pixel is (0,0).
- FSM states: IDLE, RUN, STALL.
  - IDLE: VideoReady=0. Go to RUN when Enable=1.
  - RUN: VideoReady=1. Go to IDLE if Enable=0. Go to STALL when STALL_PERIOD!=0 and the stall counter reaches STALL_PERIOD-1.
  - STALL: VideoReady=0 for exactly one cycle, then go to RUN, or to IDLE if Enable=0.
- VideoReady is a registered output; it depends only on state, never combinationally on VideoValid.
- Transfer: a pixel is consumed on any rising edge where VideoValid=1 and VideoReady=1. No other cycle changes x, y or the error state.
- Enable low: ready drops. x and y are held (pause, not restart). Re-enabling resumes at the same pixel.
- Expected pixel: COLOR_A if bit STRIPE_LOG2 of x is 0, else COLOR_B. The last partial stripe of a line (x 768..799 for defaults) follows the same rule.
- Counters:
  - x increments per transfer. At H_ACTIVE-1, x wraps to 0 and y increments.
  - At x=H_ACTIVE-1 and y=V_ACTIVE-1, both wrap to 0, FrameCount increments (wraps at 16 bits) and FrameDone pulses in the cycle after that transfer.
- Compare, registered:
  - Mismatch on transfer: ErrorCount increments one cycle later, saturating at 16'hFFFF.
  - First mismatch since reset: sets ErrorFlag and latches FirstErrX/FirstErrY. Later mismatches do not change the latched coordinates.
  - Result latency: 1 cycle from transfer to counter/flag update.
- Stall counter: advances every cycle in RUN. Resets to 0 on entering STALL or IDLE.
- Simultaneous events: a frame wrap and a mismatch on the same pixel both take effect. VideoValid=1 while VideoReady=0 has no effect; the producer must hold data.

Test Plan:
- Defaults, STALL_PERIOD=0, generator-correct stream, Enable=1 for 480000 transfers -> ErrorCount=0, ErrorFlag=0, FrameCount=1, FrameDone high exactly 1 cycle; VideoReady high 1 cycle after Enable.
- Inject 24'h000000 at pixel index 70 (x=70,y=0) and at index 900 (x=100,y=1) -> ErrorCount=2, ErrorFlag=1, FirstErrX=70, FirstErrY=0.
- STALL_PERIOD=4, correct stream with VideoValid held -> VideoReady low every 5th cycle; no errors; a full frame takes 600000 cycles after the first transfer.
- Toggle VideoValid pseudo-randomly and drop Enable for 10 cycles at x=300 -> x held during the pause; resumes at 300; no errors; FrameCount=1.
- Assert reset at x=500,y=2 with ErrorCount=3 -> all outputs 0 immediately (asynchronous); next frame starts at (0,0) and checks clean.
- Force the ErrorCount register to 16'hFFFE, then inject 3 errors -> ErrorCount stays at 16'hFFFF.

Source files
------------

// File: rtl/video_pattern_checker.sv
// Consumer-side checker for the 24-bit Video/VideoValid/VideoReady stream: compares
// each accepted pixel with the vertical-stripe pattern, counts errors and frames.
module video_pattern_checker #(
   parameter int unsigned H_ACTIVE     = 800,
   parameter int unsigned V_ACTIVE     = 600,
   parameter int unsigned STRIPE_LOG2  = 6,
   parameter logic [23:0] COLOR_A      = 24'hFF33FF,
   parameter logic [23:0] COLOR_B      = 24'hFF3333,
   parameter int unsigned STALL_PERIOD = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Enable,
   input  logic [23:0] Video,
   input  logic        VideoValid,
   output logic        VideoReady,
   output logic [15:0] ErrorCount,
   output logic [15:0] FrameCount,
   output logic        ErrorFlag,
   output logic [9:0]  FirstErrX,
   output logic [9:0]  FirstErrY,
   output logic        FrameDone
);

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   localparam logic [15:0] STALL_LAST = 16'(STALL_PERIOD - 1);
   localparam logic [9:0]  X_LAST     = 10'(H_ACTIVE - 1);
   localparam logic [9:0]  Y_LAST     = 10'(V_ACTIVE - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_ready;
   logic        w_ready_nxt;
   logic [15:0] r_stall_cnt;
   logic [9:0]  r_x;
   logic [9:0]  r_y;
   logic [15:0] r_err_cnt;
   logic [15:0] r_frame_cnt;
   logic        r_err_flag;
   logic [9:0]  r_first_x;
   logic [9:0]  r_first_y;
   logic        r_frame_done;

   logic        w_stall_hit;
   logic        w_xfer;
   logic [23:0] w_expected;
   logic        w_mismatch;
   logic        w_last_x;
   logic        w_last_y;

   assign w_stall_hit = (STALL_PERIOD != 0) && (r_stall_cnt == STALL_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_ready     <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_ready <= w_ready_nxt;
         if (r_state == RUN && w_state_nxt == RUN)
            r_stall_cnt <= r_stall_cnt + 16'd1;
         else
            r_stall_cnt <= '0;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (Enable) w_state_nxt = RUN;
         RUN: begin
            if (!Enable)          w_state_nxt = IDLE;
            else if (w_stall_hit) w_state_nxt = STALL;
         end
         STALL:   w_state_nxt = Enable ? RUN : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Ready is decoded from the next state so the registered output tracks the state exactly.
   always_comb begin
      w_ready_nxt = (w_state_nxt == RUN);
   end

   assign w_xfer     = VideoValid & r_ready;
   assign w_expected = r_x[STRIPE_LOG2] ? COLOR_B : COLOR_A;
   assign w_mismatch = w_xfer && (Video != w_expected);
   assign w_last_x   = (r_x == X_LAST);
   assign w_last_y   = (r_y == Y_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_xfer) begin
         if (w_last_x) begin
            r_x <= '0;
            r_y <= w_last_y ? '0 : r_y + 10'd1;
         end else begin
            r_x <= r_x + 10'd1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_err_cnt    <= '0;
         r_err_flag   <= 1'b0;
         r_first_x    <= '0;
         r_first_y    <= '0;
         r_frame_cnt  <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_xfer && w_last_x && w_last_y;
         if (w_xfer && w_last_x && w_last_y)
            r_frame_cnt <= r_frame_cnt + 16'd1;
         if (w_mismatch && r_err_cnt != '1)
            r_err_cnt <= r_err_cnt + 16'd1;
         if (w_mismatch && !r_err_flag) begin
            r_err_flag <= 1'b1;
            r_first_x  <= r_x;
            r_first_y  <= r_y;
         end
      end
   end

   assign VideoReady = r_ready;
   assign ErrorCount = r_err_cnt;
   assign FrameCount = r_frame_cnt;
   assign ErrorFlag  = r_err_flag;
   assign FirstErrX  = r_first_x;
   assign FirstErrY  = r_first_y;
   assign FrameDone  = r_frame_done;

endmodule

// File: tb/tb_video_pattern_checker.sv
// Randomized bench for video_pattern_checker on a reduced 44x6 frame with a stall every 4 cycles,
// checked against a pixel-index reference model.
module tb_video_pattern_checker;

   localparam int          H  = 44;
   localparam int          V  = 6;
   localparam int          SL = 3;
   localparam int          STRIPE = 1 << SL;
   localparam int          SP = 4;
   localparam int          N  = H * V;
   localparam logic [23:0] CA = 24'hFF33FF;
   localparam logic [23:0] CB = 24'hFF3333;

   logic        clock;
   logic        reset;
   logic        Enable;
   logic [23:0] Video;
   logic        VideoValid;
   logic        VideoReady;
   logic [15:0] ErrorCount;
   logic [15:0] FrameCount;
   logic        ErrorFlag;
   logic [9:0]  FirstErrX;
   logic [9:0]  FirstErrY;
   logic        FrameDone;

   int tests = 0;
   int fails = 0;

   // reference model state
   bit m_ready;
   int m_run;
   int m_idx;
   int m_err;
   bit m_flag;
   int m_fx;
   int m_fy;
   int m_frames;
   bit m_done;
   int bad_at[$];

   video_pattern_checker #(
      .H_ACTIVE(H), .V_ACTIVE(V), .STRIPE_LOG2(SL),
      .COLOR_A(CA), .COLOR_B(CB), .STALL_PERIOD(SP)
   ) u_dut (
      .clock(clock), .reset(reset), .Enable(Enable), .Video(Video),
      .VideoValid(VideoValid), .VideoReady(VideoReady), .ErrorCount(ErrorCount),
      .FrameCount(FrameCount), .ErrorFlag(ErrorFlag), .FirstErrX(FirstErrX),
      .FirstErrY(FirstErrY), .FrameDone(FrameDone)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [23:0] good_px(input int x);
      return (((x / STRIPE) % 2) == 1) ? CB : CA;
   endfunction

   task automatic model_reset();
      m_ready = 0; m_run = 0; m_idx = 0; m_err = 0; m_flag = 0;
      m_fx = 0; m_fy = 0; m_frames = 0; m_done = 0;
      bad_at.delete();
   endtask

   // One clock: drive the generator's current pixel, advance the model at the edge, return at negedge.
   task automatic step(input bit valid);
      logic [23:0] px;
      bit xfer;
      px = (bad_at.size() > 0 && bad_at[0] == m_idx) ? 24'h000000 : good_px(m_idx % H);
      Video = px;
      VideoValid = valid;
      @(posedge clock);
      xfer = valid && m_ready;
      m_done = 0;
      if (xfer) begin
         if (px !== good_px(m_idx % H)) begin
            if (m_err < 65535) m_err++;
            if (!m_flag) begin m_flag = 1; m_fx = m_idx % H; m_fy = m_idx / H; end
         end
         if (bad_at.size() > 0 && bad_at[0] == m_idx) void'(bad_at.pop_front());
         m_idx++;
         if (m_idx == N) begin m_idx = 0; m_frames = (m_frames + 1) % 65536; m_done = 1; end
      end
      if (Enable && !(m_ready && m_run == SP)) begin
         m_run = m_ready ? m_run + 1 : 1;
         m_ready = 1;
      end else begin
         m_run = 0;
         m_ready = 0;
      end
      @(negedge clock);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1; Enable = 0; VideoValid = 0;
      model_reset();
      @(negedge clock);
      reset = 0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      tests++; if (VideoReady !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", VideoReady); end
      tests++; if (ErrorCount !== 16'd0) begin fails++; $display("FAIL reset_err: got %0d want 0", ErrorCount); end
      tests++; if (FrameCount !== 16'd0) begin fails++; $display("FAIL reset_frames: got %0d want 0", FrameCount); end
      tests++; if (ErrorFlag !== 1'b0) begin fails++; $display("FAIL reset_flag: got %b want 0", ErrorFlag); end
      tests++; if (FrameDone !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", FrameDone); end
      model_reset();
      reset = 0;
      step(1);
      tests++; if (VideoReady !== 1'b0) begin fails++; $display("FAIL idle_ready: got %b want 0", VideoReady); end
   endtask

   task automatic test_full_frame();
      int done_cnt = 0;
      int done_at = -1;
      do_reset();
      Enable = 1;
      tests++; if (VideoReady !== 1'b0) begin fails++; $display("FAIL ready_before_enable: got %b want 0", VideoReady); end
      step(1);
      tests++; if (VideoReady !== 1'b1) begin fails++; $display("FAIL ready_latency: got %b want 1", VideoReady); end
      for (int i = 1; i < N + N / SP + 4; i++) begin
         step(1);
         tests++; if (VideoReady !== m_ready) begin fails++; $display("FAIL stall_ready @%0d: got %b want %b", i, VideoReady, m_ready); end
         tests++; if (FrameDone !== m_done) begin fails++; $display("FAIL frame_done @%0d: got %b want %b", i, FrameDone, m_done); end
         if (FrameDone === 1'b1) begin done_cnt++; done_at = i; end
      end
      tests++; if (done_at != N + (N - 1) / SP) begin fails++; $display("FAIL frame_cycles: got %0d want %0d", done_at, N + (N - 1) / SP); end
      tests++; if (done_cnt != 1) begin fails++; $display("FAIL done_pulses: got %0d want 1", done_cnt); end
      tests++; if (FrameCount !== 16'd1) begin fails++; $display("FAIL frame_count: got %0d want 1", FrameCount); end
      tests++; if (ErrorCount !== 16'd0) begin fails++; $display("FAIL clean_err: got %0d want 0", ErrorCount); end
      tests++; if (ErrorFlag !== 1'b0) begin fails++; $display("FAIL clean_flag: got %b want 0", ErrorFlag); end
      Enable = 0;
      step(1);
      tests++; if (VideoReady !== 1'b0) begin fails++; $display("FAIL ready_disable: got %b want 0", VideoReady); end
   endtask

   task automatic test_inject();
      int i;
      do_reset();
      bad_at = '{13, H + 20};
      Enable = 1;
      for (i = 0; i < 400 && m_idx < 80; i++) begin
         step(1);
         tests++; if (ErrorCount !== 16'(m_err)) begin fails++; $display("FAIL inject_err_track @%0d: got %0d want %0d", i, ErrorCount, m_err); end
      end
      if (m_idx < 80) begin fails++; $display("FAIL inject_timeout: got idx %0d want 80", m_idx); end
      tests++; if (ErrorCount !== 16'd2) begin fails++; $display("FAIL inject_err: got %0d want 2", ErrorCount); end
      tests++; if (ErrorFlag !== 1'b1) begin fails++; $display("FAIL inject_flag: got %b want 1", ErrorFlag); end
      tests++; if (FirstErrX !== 10'd13) begin fails++; $display("FAIL inject_x: got %0d want 13", FirstErrX); end
      tests++; if (FirstErrY !== 10'd0) begin fails++; $display("FAIL inject_y: got %0d want 0", FirstErrY); end
   endtask

   task automatic test_pause();
      bit paused = 0;
      int i;
      do_reset();
      Enable = 1;
      for (i = 0; i < 4000 && m_frames < 1; i++) begin
         if (!paused && m_idx == 30) begin
            paused = 1;
            Enable = 0;
            for (int k = 0; k < 10; k++) begin
               step(1'($urandom_range(0, 1)));
               tests++; if (VideoReady !== 1'b0) begin fails++; $display("FAIL pause_ready @%0d: got %b want 0", k, VideoReady); end
            end
            Enable = 1;
         end
         step(1'($urandom_range(0, 1)));
         tests++; if (VideoReady !== m_ready) begin fails++; $display("FAIL random_ready @%0d: got %b want %b", i, VideoReady, m_ready); end
      end
      if (m_frames < 1) begin fails++; $display("FAIL pause_timeout: got frames %0d want 1", m_frames); end
      tests++; if (ErrorCount !== 16'd0) begin fails++; $display("FAIL pause_err: got %0d want 0", ErrorCount); end
      tests++; if (FrameCount !== 16'd1) begin fails++; $display("FAIL pause_frames: got %0d want 1", FrameCount); end
      Enable = 0;
      step(0);
   endtask

   task automatic test_reset_midframe();
      int i;
      do_reset();
      bad_at = '{5, 10, 50};
      Enable = 1;
      for (i = 0; i < 1000 && m_idx != 2 * H + 25; i++) step(1);
      if (m_idx != 2 * H + 25) begin fails++; $display("FAIL midframe_timeout: got idx %0d want %0d", m_idx, 2 * H + 25); end
      tests++; if (ErrorCount !== 16'd3) begin fails++; $display("FAIL pre_reset_err: got %0d want 3", ErrorCount); end
      #2 reset = 1;
      #1;
      tests++; if (VideoReady !== 1'b0) begin fails++; $display("FAIL async_ready: got %b want 0", VideoReady); end
      tests++; if (ErrorCount !== 16'd0) begin fails++; $display("FAIL async_err: got %0d want 0", ErrorCount); end
      tests++; if (ErrorFlag !== 1'b0) begin fails++; $display("FAIL async_flag: got %b want 0", ErrorFlag); end
      tests++; if (FirstErrX !== 10'd0) begin fails++; $display("FAIL async_x: got %0d want 0", FirstErrX); end
      tests++; if (FirstErrY !== 10'd0) begin fails++; $display("FAIL async_y: got %0d want 0", FirstErrY); end
      Enable = 0; VideoValid = 0;
      model_reset();
      @(negedge clock);
      reset = 0;
      Enable = 1;
      for (i = 0; i < 2000 && m_frames < 1; i++) step(1);
      if (m_frames < 1) begin fails++; $display("FAIL post_reset_timeout: got frames %0d want 1", m_frames); end
      tests++; if (ErrorCount !== 16'd0) begin fails++; $display("FAIL post_reset_err: got %0d want 0", ErrorCount); end
      tests++; if (FrameCount !== 16'd1) begin fails++; $display("FAIL post_reset_frames: got %0d want 1", FrameCount); end
   endtask

   task automatic test_saturate();
      int i;
      do_reset();
      force u_dut.r_err_cnt = 16'hFFFE;
      #1 release u_dut.r_err_cnt;
      m_err = 65534;
      bad_at = '{2, 3, 4};
      Enable = 1;
      for (i = 0; i < 100 && m_idx < 8; i++) begin
         step(1);
         tests++; if (ErrorCount !== 16'(m_err)) begin fails++; $display("FAIL sat_track @%0d: got %h want %h", i, ErrorCount, m_err); end
      end
      if (m_idx < 8) begin fails++; $display("FAIL sat_timeout: got idx %0d want 8", m_idx); end
      tests++; if (ErrorCount !== 16'hFFFF) begin fails++; $display("FAIL sat_err: got %h want ffff", ErrorCount); end
      tests++; if (FirstErrX !== 10'd2) begin fails++; $display("FAIL sat_x: got %0d want 2", FirstErrX); end
   endtask

   task automatic test_back_to_back();
      int pulses = 0;
      int i;
      do_reset();
      bad_at = '{N - 1};
      Enable = 1;
      for (i = 0; i < 2000 && m_frames < 2; i++) begin
         step(1);
         if (FrameDone === 1'b1) pulses++;
      end
      if (m_frames < 2) begin fails++; $display("FAIL b2b_timeout: got frames %0d want 2", m_frames); end
      tests++; if (FrameCount !== 16'd2) begin fails++; $display("FAIL b2b_frames: got %0d want 2", FrameCount); end
      tests++; if (pulses != 2) begin fails++; $display("FAIL b2b_pulses: got %0d want 2", pulses); end
      tests++; if (ErrorCount !== 16'd1) begin fails++; $display("FAIL wrap_err: got %0d want 1", ErrorCount); end
      tests++; if (FirstErrX !== 10'(H - 1)) begin fails++; $display("FAIL wrap_x: got %0d want %0d", FirstErrX, H - 1); end
      tests++; if (FirstErrY !== 10'(V - 1)) begin fails++; $display("FAIL wrap_y: got %0d want %0d", FirstErrY, V - 1); end
   endtask

   initial begin
      reset = 1; Enable = 0; VideoValid = 0; Video = '0;
      model_reset();
      test_reset();
      test_full_frame();
      test_inject();
      test_pause();
      test_reset_midframe();
      test_saturate();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
